// File: rtl/gpio_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gpio_pattern_gen: multi-channel test-pattern driver (toggle/walk/PRBS7/count), rev 1.0
// Optional macro PATGEN_INVERT_EN adds a start-latched XOR mask on the outputs.
// ---------------------------------------------------------------------------
module gpio_pattern_gen #(
  parameter int N_CH  = 40,
  parameter int DIV_W = 24,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [1:0]       mode_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [LEN_W-1:0] run_len_i,
`ifdef PATGEN_INVERT_EN
  input  logic [N_CH-1:0]  invert_mask_i,
`endif
  output logic [N_CH-1:0]  out_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0]       MODE_TOGGLE = 2'd0;
  localparam logic [1:0]       MODE_WALK   = 2'd1;
  localparam logic [1:0]       MODE_PRBS   = 2'd2;
  localparam logic [N_CH-1:0]  PAT_ONE     = {{(N_CH-1){1'b0}}, 1'b1};
  localparam logic [DIV_W-1:0] PRESC_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] REM_ONE     = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [6:0]       LFSR_SEED   = 7'h7F;

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] presc_q;
  logic [LEN_W-1:0] rem_q;
  logic             bounded_q;
  logic [N_CH-1:0]  pat_q;
  logic [N_CH-1:0]  pat_d;
  logic [6:0]       lfsr_q;
  logic [6:0]       lfsr_d;
  logic             busy_q;
  logic             done_q;
  logic             prbs_bit;
  logic             tick_now;
`ifdef PATGEN_INVERT_EN
  logic [N_CH-1:0]  mask_q;
`endif

  assign tick_now = (state_q == S_RUN) && (presc_q == div_q);
  assign prbs_bit = lfsr_q[6] ^ lfsr_q[5];

  always_comb begin
    pat_d  = pat_q;
    lfsr_d = lfsr_q;
    case (mode_q)
      MODE_TOGGLE: pat_d = ~pat_q;
      MODE_WALK:   pat_d = {pat_q[N_CH-2:0], pat_q[N_CH-1]};
      MODE_PRBS: begin
        pat_d  = {pat_q[N_CH-2:0], prbs_bit};
        lfsr_d = {lfsr_q[5:0], prbs_bit};
      end
      default:     pat_d = pat_q + PAT_ONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_TOGGLE;
      div_q     <= '0;
      presc_q   <= '0;
      rem_q     <= '0;
      bounded_q <= 1'b0;
      pat_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef PATGEN_INVERT_EN
      mask_q    <= '0;
`endif
    end else if (stop_i) begin
      // Abort wins over everything else, including a same-cycle start.
      state_q <= S_IDLE;
      presc_q <= '0;
      rem_q   <= '0;
      pat_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q   <= S_RUN;
            mode_q    <= mode_i;
            div_q     <= div_i;
            presc_q   <= '0;
            rem_q     <= run_len_i;
            bounded_q <= (run_len_i != '0);
            lfsr_q    <= LFSR_SEED;
            pat_q     <= (mode_i == MODE_WALK) ? PAT_ONE : '0;
            busy_q    <= 1'b1;
`ifdef PATGEN_INVERT_EN
            mask_q    <= invert_mask_i;
`endif
          end
        end
        S_RUN: begin
          if (tick_now) begin
            presc_q <= '0;
            pat_q   <= pat_d;
            lfsr_q  <= lfsr_d;
            if (bounded_q) begin
              rem_q <= rem_q - REM_ONE;
              if (rem_q == REM_ONE) begin
                state_q <= S_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end
          end else begin
            presc_q <= presc_q + PRESC_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PATGEN_INVERT_EN
  assign out_o = pat_q ^ mask_q;
`else
  assign out_o = pat_q;
`endif
  assign tick_o = tick_now;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule
`default_nettype wire

// File: tb/tb_gpio_pattern_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gpio_pattern_gen: scoreboard bench for gpio_pattern_gen (8- and 4-channel builds), rev 1.0
// ---------------------------------------------------------------------------
module tb_gpio_pattern_gen;

  localparam int M_TOGGLE = 0;
  localparam int M_WALK   = 1;
  localparam int M_PRBS   = 2;
  localparam int M_COUNT  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start8 = 1'b0;
  logic        start4 = 1'b0;
  logic        stop = 1'b0;
  logic [1:0]  mode_s = 2'd0;
  logic [23:0] div_s = '0;
  logic [15:0] len_s = '0;
  logic [7:0]  mask8 = 8'h00;
  logic [7:0]  out8;
  logic [3:0]  out4;
  logic        tick8, busy8, done8, tick4, busy4, done4;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  gpio_pattern_gen #(.N_CH(8), .DIV_W(24), .LEN_W(16)) u_dut8 (
    .clk(clk), .rst(rst), .start_i(start8), .stop_i(stop), .mode_i(mode_s),
    .div_i(div_s), .run_len_i(len_s),
`ifdef PATGEN_INVERT_EN
    .invert_mask_i(mask8),
`endif
    .out_o(out8), .tick_o(tick8), .busy_o(busy8), .done_o(done8)
  );

  gpio_pattern_gen #(.N_CH(4), .DIV_W(24), .LEN_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .stop_i(stop), .mode_i(mode_s),
    .div_i(div_s), .run_len_i(len_s),
`ifdef PATGEN_INVERT_EN
    .invert_mask_i(4'h0),
`endif
    .out_o(out4), .tick_o(tick4), .busy_o(busy4), .done_o(done4)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference sequence: initial pattern followed by ln advances.
  task automatic push_run(input int mode, input int ln, input int w, input logic [7:0] msk);
    logic [7:0] wm;
    logic [7:0] p;
    logic [6:0] l;
    logic       nb;
    wm = (w == 8) ? 8'hFF : 8'h0F;
    p  = (mode == M_WALK) ? 8'h01 : 8'h00;
    l  = 7'h7F;
    exp_q.push_back(p ^ msk);
    for (int i = 0; i < ln; i++) begin
      case (mode)
        M_TOGGLE: p = ~p & wm;
        M_WALK:   p = ((p << 1) | (p >> (w - 1))) & wm;
        M_PRBS: begin
          nb = l[6] ^ l[5];
          l  = {l[5:0], nb};
          p  = ((p << 1) | {7'b0, nb}) & wm;
        end
        default:  p = (p + 8'd1) & wm;
      endcase
      exp_q.push_back(p ^ msk);
    end
  endtask

  task automatic run(input int sel, input int mode, input int dv, input int ln,
                     input int samples, input bit poke);
    int per;
    int lim;
    per    = dv + 1;
    lim    = ln * per;
    mode_s = 2'(mode);
    div_s  = 24'(dv);
    len_s  = 16'(ln);
    if (sel == 0) start8 = 1'b1; else start4 = 1'b1;
    cyc();
    start8 = 1'b0;
    start4 = 1'b0;
    for (int c = 1; c <= samples; c++) begin
      logic [7:0] o;
      logic t, b, d, et, eb, ed;
      o = (sel == 0) ? out8 : {4'h0, out4};
      t = (sel == 0) ? tick8 : tick4;
      b = (sel == 0) ? busy8 : busy4;
      d = (sel == 0) ? done8 : done4;
      eb = (ln == 0) || (c <= lim);
      et = eb && ((c % per) == 0);
      ed = (ln != 0) && (c == lim + 1);
      chk("tick", t, et);
      chk("busy", b, eb);
      chk("done", d, ed);
      if (t || d) begin
        chk("sb_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) chk("out", o, exp_q.pop_front());
      end
      // Late start with different parameters must be ignored while running.
      if (poke && c == 2) begin
        mode_s = (mode == M_TOGGLE) ? 2'd1 : 2'd0;
        div_s  = 24'd0;
        len_s  = 16'd2;
        if (sel == 0) start8 = 1'b1; else start4 = 1'b1;
      end
      if (poke && c == 3) begin
        start8 = 1'b0;
        start4 = 1'b0;
      end
      cyc();
    end
    chk("sb_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
`ifdef PATGEN_INVERT_EN
    mask8 = 8'hAA;
`endif
    cyc();
    cyc();
    chk("rst_out8", out8, 8'h00);
    chk("rst_out4", out4, 4'h0);
    chk("rst_tick", tick8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    rst = 1'b0;
    cyc();

    // WALK, div=0, 10 steps: 01..80,01,02 then 04 held
    push_run(M_WALK, 10, 8, mask8);
    run(0, M_WALK, 0, 10, 14, 1'b0);
    chk("walk_hold", out8, 8'h04 ^ mask8);

    // TOGGLE free-run, tick every 4th cycle, then stop
    push_run(M_TOGGLE, 4, 8, mask8);
    run(0, M_TOGGLE, 3, 0, 20, 1'b0);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop_out", out8, mask8);
    chk("stop_busy", busy8, 0);
    chk("stop_done", done8, 0);
    cyc();

    // PRBS7 full period from seed 7F
    push_run(M_PRBS, 127, 8, mask8);
    run(0, M_PRBS, 0, 127, 130, 1'b0);
    chk("prbs_lfsr", u_dut8.lfsr_q, 7'h7F);

    // COUNT on 4 channels, div=1, 18 steps: wraps, ends at 2
    push_run(M_COUNT, 18, 4, 8'h00);
    run(1, M_COUNT, 1, 18, 40, 1'b0);
    chk("count_end", out4, 4'h2);

    // Start while busy with changed parameters is ignored
    push_run(M_WALK, 4, 8, mask8);
    run(0, M_WALK, 1, 4, 12, 1'b1);
    chk("poke_hold", out8, 8'h10 ^ mask8);

    // Simultaneous start and stop: stays idle, pattern cleared
    mode_s = 2'd1;
    div_s  = 24'd0;
    len_s  = 16'd5;
    start8 = 1'b1;
    stop   = 1'b1;
    cyc();
    start8 = 1'b0;
    stop   = 1'b0;
    chk("ss_busy", busy8, 0);
    chk("ss_out", out8, mask8);
    cyc();
    chk("ss_busy2", busy8, 0);
    chk("ss_tick", tick8, 0);

    // Reset in the middle of a free run
    mode_s = 2'd1;
    div_s  = 24'd0;
    len_s  = 16'd0;
    start8 = 1'b1;
    cyc();
    start8 = 1'b0;
    cyc();
    cyc();
    chk("mid_busy", busy8, 1);
    rst = 1'b1;
    cyc();
    chk("mrst_out", out8, 8'h00);
    chk("mrst_busy", busy8, 0);
    chk("mrst_tick", tick8, 0);
    chk("mrst_done", done8, 0);
    rst = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
